// File: rtl/spm_host.sv
// -----------------------------------------------------------------------------
// spm_host : handshake host for a sequential (shift/add) multiplier.
//
// Accepts one operand pair through a valid/ready input port, holds the operands
// steady on mc/mp while it drives start to the multiplier controller, then
// captures the product and offers it through a valid/ready result port.
// There is no operand buffering: one operation is in flight at a time.
//
// State sequence: IDLE -> LOAD -> RUN -> RESULT -> IDLE.
//   LOAD gives the multiplier one idle/load cycle with stable operands.
//   RESULT keeps start low, so the multiplier always sees a low start cycle
//   between two operations.
//
// Optional feature (macro SPM_HOST_TIMEOUT_EN):
//   When defined, an 8-bit counter watches the RUN state. If TIMEOUT RUN cycles
//   pass without done, the operation is aborted and RESULT is entered with
//   out_prod=0 and out_err=1. A done on that last cycle still wins.
//   When undefined, out_err is tied low and RUN waits for done indefinitely.
//
// Reset: rst, asynchronous, active-high. It abandons any operation and drops
// start at once.
// -----------------------------------------------------------------------------
module spm_host #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mc,
    input  logic [WIDTH-1:0]     in_mp,
    output logic                 start,
    output logic [WIDTH-1:0]     mc,
    output logic [WIDTH-1:0]     mp,
    input  logic                 done,
    input  logic [2*WIDTH-1:0]   prod_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 out_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    // Abort threshold for the 8-bit RUN counter.
    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_start;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [WIDTH-1:0]      r_mc;
    logic [WIDTH-1:0]      r_mp;
    logic [2*WIDTH-1:0]    r_out_prod;

`ifdef SPM_HOST_TIMEOUT_EN
    logic [7:0]            r_cnt;
    logic                  r_err;
    logic [7:0]            w_cnt_next;

    // Value the RUN counter takes at the end of the current RUN cycle.
    assign w_cnt_next = r_cnt + 8'd1;
`else
    // The threshold has no consumer when the timeout is compiled out.
    logic [7:0]            w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_C;
`endif

    // Control FSM with registered handshake, start, busy and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_mc        <= '0;
            r_mp        <= '0;
            r_out_prod  <= '0;
`ifdef SPM_HOST_TIMEOUT_EN
            r_cnt       <= 8'd0;
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mc       <= in_mc;
                        r_mp       <= in_mp;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end

                S_LOAD: begin
                    // One quiet cycle with stable operands, then request.
                    r_start <= 1'b1;
                    r_state <= S_RUN;
`ifdef SPM_HOST_TIMEOUT_EN
                    r_cnt   <= 8'd0;
`endif
                end

                S_RUN: begin
                    if (done) begin
                        // done wins even on the cycle the counter expires.
                        r_out_prod  <= prod_in;
                        r_start     <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_RESULT;
`ifdef SPM_HOST_TIMEOUT_EN
                        r_err       <= 1'b0;
`endif
                    end else begin
`ifdef SPM_HOST_TIMEOUT_EN
                        if (w_cnt_next == TIMEOUT_C) begin
                            r_out_prod  <= '0;
                            r_err       <= 1'b1;
                            r_start     <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_RESULT;
                        end else begin
                            r_cnt       <= w_cnt_next;
                            r_state     <= S_RUN;
                        end
`else
                        r_state <= S_RUN;
`endif
                    end
                end

                S_RESULT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state     <= S_RESULT;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_start     <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign start     = r_start;
    assign mc        = r_mc;
    assign mp        = r_mp;
    assign out_valid = r_out_valid;
    assign out_prod  = r_out_prod;
    assign busy      = r_busy;

`ifdef SPM_HOST_TIMEOUT_EN
    assign out_err   = r_err;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spm_host.sv
// -----------------------------------------------------------------------------
// tb_spm_host : directed self-checking bench for spm_host (WIDTH=8, TIMEOUT=20).
// A small multiplier model raises done after a programmable number of start-high
// cycles and presents mc*mp on prod_in.
// -----------------------------------------------------------------------------
module tb_spm_host;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_mc;
    logic [7:0]   in_mp;
    logic         start;
    logic [7:0]   mc;
    logic [7:0]   mp;
    logic         done;
    logic [15:0]  prod_in;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_prod;
    logic         out_err;
    logic         busy;

    int checks;
    int errors;

    // multiplier model controls
    int   m_cnt;
    int   done_at;
    logic done_en;
    logic done_force;
    logic overlap_bad;

    spm_host #(.WIDTH(8), .TIMEOUT(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mc     (in_mc),
        .in_mp     (in_mp),
        .start     (start),
        .mc        (mc),
        .mp        (mp),
        .done      (done),
        .prod_in   (prod_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier model: counts start-high cycles, done on the done_at-th one
    always @(posedge clk) begin
        if (!start) m_cnt <= 0;
        else        m_cnt <= m_cnt + 1;
    end
    assign done    = done_force | (done_en & start & (m_cnt == done_at - 1));
    assign prod_in = {8'd0, mc} * {8'd0, mp};

    // handshake exclusivity monitor
    always @(negedge clk) begin
        if (!rst && in_ready && out_valid) overlap_bad <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one complete operation with optional out_ready back-pressure
    task automatic op(input logic [7:0] a, input logic [7:0] b, input int hold,
                      input int exp_cycles, input logic [15:0] exp_prod, input logic exp_err);
        int runc;
        bit stable;
        bit seen;
        in_mc    = a;
        in_mp    = b;
        in_valid = 1'b1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("load_in_ready", {31'd0, in_ready}, 32'd0);
        chk("load_start",    {31'd0, start},    32'd0);
        chk("load_busy",     {31'd0, busy},     32'd1);
        chk("load_mc",       {24'd0, mc},       {24'd0, a});
        chk("load_mp",       {24'd0, mp},       {24'd0, b});
        runc   = 0;
        stable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            runc++;
            if (start !== 1'b1 || mc !== a || mp !== b || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("result_seen",   {31'd0, seen},     32'd1);
        chk("run_cycles",    runc,              exp_cycles);
        chk("run_stable",    {31'd0, stable},   32'd1);
        chk("res_prod",      {16'd0, out_prod}, {16'd0, exp_prod});
        chk("res_err",       {31'd0, out_err},  {31'd0, exp_err});
        chk("res_start",     {31'd0, start},    32'd0);
        chk("res_in_ready",  {31'd0, in_ready}, 32'd0);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_prod !== exp_prod || in_ready !== 1'b0 || start !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rel_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rel_busy",      {31'd0, busy},      32'd0);
    endtask

    logic [15:0] got[$];
    int  nacc;
    int  lows;
    int  gap;
    bit  seen_start;
    bit  was_start;
    bit  acc;
    bit  rcv;
    bit  quiet;

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_mc       = 8'd0;
        in_mp       = 8'd0;
        out_ready   = 1'b0;
        done_at     = 8;
        done_en     = 1'b1;
        done_force  = 1'b0;
        overlap_bad = 1'b0;
        m_cnt       = 0;
        tick();
        tick();
        // reset state
        chk("rst_start",     {31'd0, start},     32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_err",   {31'd0, out_err},   32'd0);
        chk("rst_mc",        {24'd0, mc},        32'd0);
        chk("rst_mp",        {24'd0, mp},        32'd0);
        chk("rst_out_prod",  {16'd0, out_prod},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        rst = 1'b0;
        tick();

        // done outside RUN is ignored
        done_force = 1'b1;
        tick();
        tick();
        done_force = 1'b0;
        chk("idle_done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_done_busy",      {31'd0, busy},      32'd0);

        // basic operation and full-scale operands with back-pressure
        op(8'd3,   8'd5,   0,  8, 16'd15,    1'b0);
        op(8'd255, 8'd255, 10, 8, 16'd65025, 1'b0);

        // back-to-back pairs with in_valid held high
        out_ready  = 1'b1;
        in_mc      = 8'd2;
        in_mp      = 8'd7;
        in_valid   = 1'b1;
        nacc       = 0;
        lows       = 0;
        gap        = 0;
        seen_start = 1'b0;
        was_start  = 1'b0;
        for (int i = 0; i < 100 && got.size() < 2; i++) begin
            acc = in_valid && in_ready;
            rcv = out_valid && out_ready;
            if (rcv) got.push_back(out_prod);
            tick();
            if (acc) begin
                nacc++;
                if (nacc == 1) begin
                    in_mc = 8'd9;
                    in_mp = 8'd9;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (start) begin
                if (!was_start && seen_start) gap = lows;
                seen_start = 1'b1;
                lows = 0;
            end else begin
                lows++;
            end
            was_start = start;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_count",   got.size(), 32'd2);
        chk("b2b_first",   {16'd0, (got.size() > 0) ? got[0] : 16'd0}, 32'd14);
        chk("b2b_second",  {16'd0, (got.size() > 1) ? got[1] : 16'd0}, 32'd81);
        chk("b2b_gap_ge2", {31'd0, (gap >= 2)}, 32'd1);
        tick();

        // reset pulsed at RUN cycle 4
        in_mc    = 8'd6;
        in_mp    = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_run_start", {31'd0, start}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_start",     {31'd0, start},     32'd0);
        chk("arst_busy",      {31'd0, busy},      32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        rst   = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0 || start !== 1'b0) quiet = 1'b0;
        end
        chk("arst_no_result", {31'd0, quiet}, 32'd1);
        op(8'd4, 8'd4, 0, 8, 16'd16, 1'b0);

`ifdef SPM_HOST_TIMEOUT_EN
        // done never comes: abort after 20 RUN cycles
        done_en = 1'b0;
        op(8'd11, 8'd3, 0, 20, 16'd0, 1'b1);
        // done on RUN cycle 20 beats the timeout
        done_en = 1'b1;
        done_at = 20;
        op(8'd11, 8'd3, 0, 20, 16'd33, 1'b0);
`else
        // without the timeout, RUN waits past TIMEOUT cycles for done
        done_at = 30;
        op(8'd11, 8'd3, 0, 30, 16'd33, 1'b0);
`endif

        chk("no_ready_overlap", {31'd0, overlap_bad}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
